// File: rtl/alu_arbiter.sv
`default_nettype none
// =============================================================================
// Module : alu_arbiter
// Two-requester round-robin front end for a shared combinational ALU.
// Rev    : 1.0
// =============================================================================
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [DATA_WIDTH-1:0] r0_a,
  input  logic [DATA_WIDTH-1:0] r0_b,
  input  logic [1:0]            r0_op,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [DATA_WIDTH-1:0] r1_a,
  input  logic [DATA_WIDTH-1:0] r1_b,
  input  logic [1:0]            r1_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [1:0]            alu_option,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_id,
  input  logic                  rsp_ready
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_EXEC = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  logic [1:0] r_state;
  logic       r_id;
  logic       r_last_grant;

  logic       w_idle;
  logic       w_grant0;
  logic       w_grant1;

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  assign w_idle   = (r_state == C_IDLE) && rst_n;
  assign w_grant0 = w_idle && r0_valid && (!r1_valid ||  r_last_grant);
  assign w_grant1 = w_idle && r1_valid && (!r0_valid || !r_last_grant);

  assign r0_ready = w_grant0;
  assign r1_ready = w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= C_IDLE;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_option   <= 2'b00;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_grant0) begin
            alu_a        <= r0_a;
            alu_b        <= r0_b;
            alu_option   <= r0_op;
            r_id         <= 1'b0;
            r_last_grant <= 1'b0;
            r_state      <= C_EXEC;
          end else if (w_grant1) begin
            alu_a        <= r1_a;
            alu_b        <= r1_b;
            alu_option   <= r1_op;
            r_id         <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= C_EXEC;
          end
        end
        C_EXEC: begin
          rsp_data  <= alu_out;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= C_RESP;
        end
        C_RESP: begin
          // Returning to IDLE here means no acceptance in the consume cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= C_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          r_state   <= C_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// =============================================================================
// Module : tb_alu_arbiter
// Directed self-checking bench for alu_arbiter with a behavioural shared ALU.
// Rev    : 1.0
// =============================================================================
module tb_alu_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_valid = 1'b0, r1_valid = 1'b0;
  logic          r0_ready, r1_ready;
  logic [DW-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic [1:0]    r0_op = 2'b00, r1_op = 2'b00;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [1:0]    alu_option;
  logic          rsp_valid, rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_option(alu_option), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_option)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
  end

  // Inputs change at posedge+1, outputs are observed at posedge+2.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [1:0] op, output logic [DW-1:0] d, output logic rid);
    bit got;
    d   = '0;
    rid = 1'b0;
    if (id == 1'b0) begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op; end
    else            begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op; end
    #1;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      if ((id == 1'b0 && r0_ready) || (id == 1'b1 && r1_ready)) got = 1'b1;
      else begin tick; #1; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL issue_accept: ready got 0 expected 1 for id %0d", id);
      r0_valid = 1'b0; r1_valid = 1'b0;
      return;
    end
    tick;
    if (id == 1'b0) r0_valid = 1'b0; else r1_valid = 1'b0;
    #1;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      if (rsp_valid) got = 1'b1;
      else begin tick; #1; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL issue_rsp: rsp_valid got 0 expected 1 for id %0d", id);
      return;
    end
    d   = rsp_data;
    rid = rsp_id;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
    tick; tick; #1;
    checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL rst_r0_ready: got %b expected 0", r0_ready); end
    checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL rst_r1_ready: got %b expected 0", r1_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rst_rsp_id: got %b expected 0", rsp_id); end
    checks++; if (alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL rst_alu_ab: got %h/%h expected 0/0", alu_a, alu_b); end
    checks++; if (alu_option !== 2'b00) begin errors++; $display("FAIL rst_alu_option: got %b expected 00", alu_option); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    tick;
    rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 32'd7; r0_b = 32'd5; r0_op = 2'b00;
    #1;
    checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL single_ready_c0: got r0=%b r1=%b expected r0=1 r1=0", r0_ready, r1_ready); end
    tick; r0_valid = 1'b0; #1;
    checks++; if (r0_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec_c1: got ready=%b rsp_valid=%b expected 0/0", r0_ready, rsp_valid); end
    checks++; if (alu_a !== 32'd7 || alu_b !== 32'd5 || alu_option !== 2'b00) begin errors++; $display("FAIL single_alu_ops: got %h/%h/%b expected 7/5/00", alu_a, alu_b, alu_option); end
    tick; #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid_c2: got %b expected 1", rsp_valid); end
    checks++; if (rsp_data !== 32'd12) begin errors++; $display("FAIL single_rsp_data: got %h expected 0000000c", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id: got %b expected 0", rsp_id); end
    tick; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got rsp_valid %b expected 0", rsp_valid); end
  endtask

  task automatic test_ops_sweep;
    logic [DW-1:0] exp_d [3];
    logic [DW-1:0] d;
    logic          rid;
    exp_d[0] = 32'h0E0F_F1F0;
    exp_d[1] = 32'h000F_0000;
    exp_d[2] = 32'h0FFF_0FF0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      issue(1'b1, 32'h0F0F_00F0, 32'h00FF_0F00, 2'(i + 1), d, rid);
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL sweep_data op%0d: got %h expected %h", i + 1, d, exp_d[i]); end
      checks++; if (rid !== 1'b1) begin errors++; $display("FAIL sweep_id op%0d: got %b expected 1", i + 1, rid); end
    end
    tick;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] d;
    logic          rid;
    tick;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_1234, 32'h0000_0100, 2'b00, d, rid);
    checks++; if (d !== 32'h0000_1334 || rid !== 1'b0) begin errors++; $display("FAIL bp_first: got %h id %b expected 00001334 id 0", d, rid); end
    r0_valid = 1'b1; r0_a = 32'hAAAA_0000; r0_op = 2'b11;
    r1_valid = 1'b1; r1_a = 32'h5555_0000; r1_op = 2'b10;
    for (int c = 0; c < 5; c++) begin
      tick; #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_1334 || rsp_id !== 1'b0) begin
        errors++; $display("FAIL bp_hold c%0d: got v=%b d=%h id=%b expected 1/00001334/0", c, rsp_valid, rsp_data, rsp_id);
      end
      checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d: got %b%b expected 00", c, r0_ready, r1_ready); end
    end
    rsp_ready = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b1 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL bp_consume_cycle: got v=%b ready=%b%b expected 1/00", rsp_valid, r0_ready, r1_ready); end
    tick; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_cleared: got %b expected 0", rsp_valid); end
    // r0 won last, so the tie in the following IDLE cycle goes to r1.
    checks++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin errors++; $display("FAIL bp_idle_grant: got r0=%b r1=%b expected r0=0 r1=1", r0_ready, r1_ready); end
    r0_valid = 1'b0; r1_valid = 1'b0; #1;
    checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL bp_withdraw: got r1_ready %b expected 0", r1_ready); end
    tick; tick;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_phantom: got rsp_valid %b expected 0", rsp_valid); end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] d;
    logic          rid;
    tick;
    rsp_ready = 1'b1;
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, d, rid);
    checks++; if (d !== 32'h0 || rid !== 1'b0) begin errors++; $display("FAIL wrap: got %h id %b expected 00000000 id 0", d, rid); end
    tick;
  endtask

  task automatic test_tie;
    int            g[$];
    logic [DW-1:0] rd[$];
    int            ri[$];
    logic [DW-1:0] exp_d [3];
    int            exp_g [3];
    int            exp_i [3];
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0;
    exp_d[0] = 32'd2; exp_d[1] = 32'hFFFF_FFFF; exp_d[2] = 32'd2;
    exp_i[0] = 0; exp_i[1] = 1; exp_i[2] = 0;
    tick;
    rst_n = 1'b0; tick; tick; rst_n = 1'b1;
    tick;
    rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd1; r0_op = 2'b00;
    r1_valid = 1'b1; r1_a = 32'd0; r1_b = 32'd1; r1_op = 2'b01;
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++; if (r0_ready && r1_ready) begin errors++; $display("FAIL tie_both_ready c%0d: got 11 expected at most one", c); end
      checks++; if (rsp_valid && (r0_ready || r1_ready)) begin errors++; $display("FAIL tie_accept_in_resp c%0d: got ready %b%b expected 00", c, r0_ready, r1_ready); end
      if (r0_ready) g.push_back(0);
      if (r1_ready) g.push_back(1);
      if (rsp_valid) begin rd.push_back(rsp_data); ri.push_back(int'(rsp_id)); end
      tick;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    checks++;
    if (g.size() < 3 || rd.size() < 3) begin
      errors++; $display("FAIL tie_count: got %0d grants %0d responses expected at least 3/3", g.size(), rd.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (g[k] != exp_g[k]) begin errors++; $display("FAIL tie_grant%0d: got %0d expected %0d", k, g[k], exp_g[k]); end
        checks++; if (rd[k] !== exp_d[k] || ri[k] != exp_i[k]) begin errors++; $display("FAIL tie_rsp%0d: got %h id %0d expected %h id %0d", k, rd[k], ri[k], exp_d[k], exp_i[k]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    tick;
    rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 32'h55; r0_b = 32'h22; r0_op = 2'b10;
    #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b expected 1", r0_ready); end
    tick;
    rst_n = 1'b0;
    #1;
    checks++; if (alu_a !== '0 || alu_b !== '0 || alu_option !== 2'b00) begin errors++; $display("FAIL mid_alu: got %h/%h/%b expected 0/0/00", alu_a, alu_b, alu_option); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== 1'b0) begin errors++; $display("FAIL mid_rsp: got v=%b d=%h id=%b expected 0/0/0", rsp_valid, rsp_data, rsp_id); end
    checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset: got %b%b expected 00", r0_ready, r1_ready); end
    r0_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick; #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp c%0d: got %b expected 0", c, rsp_valid); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_ops_sweep;
    test_backpressure;
    test_wrap;
    test_tie;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
